// File: rtl/a5_keystream_wb.sv
// A5/1 keystream generator behind a Wishbone classic slave: key/frame load,
// 100-cycle mix, then 32-bit keystream words delivered one read at a time.
module a5_keystream_wb #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    typedef enum logic [2:0] {
        IDLE, LOAD_KEY, LOAD_FRAME, MIX, GEN, READY
    } state_t;

    state_t      state_q;
    logic [6:0]  cnt_q;
    logic [18:0] r1_q;
    logic [21:0] r2_q;
    logic [22:0] r3_q;
    logic [31:0] key_lo_q, key_hi_q;
    logic [21:0] frame_q;
    logic [63:0] key_snap_q;
    logic [21:0] frame_snap_q;
    logic [31:0] data_q;
    logic        valid_q;
    logic        ack_q;
    logic [31:0] dat_o_q;

    logic        unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // Bus decode
    logic        hit, req, wr, rd, start, data_read, busy;
    logic [2:0]  off;
    logic [31:0] rdata;

    assign hit       = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign off       = wbs_adr_i[4:2];
    assign req       = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign wr        = req & wbs_we_i;
    assign rd        = req & ~wbs_we_i;
    assign start     = wr & (off == 3'd3) & wbs_dat_i[0];
    assign data_read = rd & (off == 3'd5) & (state_q == READY);
    assign busy      = (state_q == LOAD_KEY) | (state_q == LOAD_FRAME) |
                       (state_q == MIX) | (state_q == GEN);

    always_comb begin
        rdata = 32'h0;
        case (off)
            3'd0:    rdata = key_lo_q;
            3'd1:    rdata = key_hi_q;
            3'd2:    rdata = {10'b0, frame_q};
            3'd4:    rdata = {30'b0, valid_q, busy};
            3'd5:    rdata = valid_q ? data_q : 32'h0;
            default: rdata = 32'h0;
        endcase
    end

    // LFSR step logic: load states step every register with an injected bit,
    // mix/gen states step only registers whose clock bit agrees with the majority.
    logic        inject, maj, load_phase;
    logic [18:0] r1_step, r1_d;
    logic [21:0] r2_step, r2_d;
    logic [22:0] r3_step, r3_d;
    logic        ks_bit;

    always_comb begin
        inject = 1'b0;
        if (state_q == LOAD_KEY)
            inject = key_snap_q[cnt_q[5:0]];
        else if (state_q == LOAD_FRAME)
            inject = frame_snap_q[cnt_q[4:0]];
    end

    assign load_phase = (state_q == LOAD_KEY) | (state_q == LOAD_FRAME);
    assign maj = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);

    assign r1_step = {r1_q[17:0], r1_q[18] ^ r1_q[17] ^ r1_q[16] ^ r1_q[13] ^ inject};
    assign r2_step = {r2_q[20:0], r2_q[21] ^ r2_q[20] ^ inject};
    assign r3_step = {r3_q[21:0], r3_q[22] ^ r3_q[21] ^ r3_q[20] ^ r3_q[7] ^ inject};

    assign r1_d = (load_phase | (r1_q[8]  == maj)) ? r1_step : r1_q;
    assign r2_d = (load_phase | (r2_q[10] == maj)) ? r2_step : r2_q;
    assign r3_d = (load_phase | (r3_q[10] == maj)) ? r3_step : r3_q;

    assign ks_bit = r1_d[18] ^ r2_d[21] ^ r3_d[22];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 7'd0;
            r1_q         <= '0;
            r2_q         <= '0;
            r3_q         <= '0;
            key_lo_q     <= '0;
            key_hi_q     <= '0;
            frame_q      <= '0;
            key_snap_q   <= '0;
            frame_snap_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ack_q        <= 1'b0;
            dat_o_q      <= '0;
        end else begin
            ack_q   <= req;
            dat_o_q <= rd ? rdata : 32'h0;

            if (wr && off == 3'd0) key_lo_q <= wbs_dat_i;
            if (wr && off == 3'd1) key_hi_q <= wbs_dat_i;
            if (wr && off == 3'd2) frame_q  <= wbs_dat_i[21:0];

            // A start always wins, even mid-run or while a word is waiting.
            if (start) begin
                r1_q         <= '0;
                r2_q         <= '0;
                r3_q         <= '0;
                key_snap_q   <= {key_hi_q, key_lo_q};
                frame_snap_q <= frame_q;
                cnt_q        <= 7'd0;
                valid_q      <= 1'b0;
                state_q      <= LOAD_KEY;
            end else begin
                case (state_q)
                    LOAD_KEY: begin
                        r1_q <= r1_d;
                        r2_q <= r2_d;
                        r3_q <= r3_d;
                        if (cnt_q == 7'd63) begin
                            cnt_q   <= 7'd0;
                            state_q <= LOAD_FRAME;
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                    LOAD_FRAME: begin
                        r1_q <= r1_d;
                        r2_q <= r2_d;
                        r3_q <= r3_d;
                        if (cnt_q == 7'd21) begin
                            cnt_q   <= 7'd0;
                            state_q <= MIX;
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                    MIX: begin
                        r1_q <= r1_d;
                        r2_q <= r2_d;
                        r3_q <= r3_d;
                        if (cnt_q == 7'd99) begin
                            cnt_q   <= 7'd0;
                            state_q <= GEN;
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                    GEN: begin
                        r1_q   <= r1_d;
                        r2_q   <= r2_d;
                        r3_q   <= r3_d;
                        data_q <= {data_q[30:0], ks_bit};
                        if (cnt_q == 7'd31) begin
                            cnt_q   <= 7'd0;
                            valid_q <= 1'b1;
                            state_q <= READY;
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                    READY: begin
                        if (data_read) begin
                            valid_q <= 1'b0;
                            cnt_q   <= 7'd0;
                            state_q <= GEN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;

endmodule

// File: tb/tb_a5_keystream_wb.sv
// Directed bench for a5_keystream_wb: register map, keystream words against
// the published A5/1 vector, exact ready timing, restart and reset behaviour.
module tb_a5_keystream_wb;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    logic [31:0] q;
    int          a, a2, r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    a5_keystream_wb #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Request is driven in the current cycle; ack must arrive after one edge.
    task automatic bus(input logic w, input logic [4:0] o, input logic [31:0] d,
                       output logic [31:0] qo, output int ack_at);
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {27'b0, o}; wdat = d;
        @(posedge clk); #1;
        ack_at = cyc_cnt;
        qo = rdat;
        chk("ack_latency", {31'b0, ack}, 32'd1);
        $display("wb %s off=%02h data=%08h ack@%0d", w ? "WR" : "RD", o, w ? d : qo, ack_at);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [4:0] o, input logic [31:0] d);
        logic [31:0] dq;
        int          t;
        bus(1'b1, o, d, dq, t);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] o, input logic [31:0] exp);
        logic [31:0] dq;
        int          t;
        bus(1'b0, o, 32'h0, dq, t);
        chk(tag, dq, exp);
    endtask

    task automatic wait_cycle(input int k);
        if (cyc_cnt > k) chk("schedule", cyc_cnt, k);
        while (cyc_cnt < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic probe_miss(input logic [31:0] addr);
        logic seen;
        seen = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = addr;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | ack;
        end
        cyc = 1'b0; stb = 1'b0;
        $display("wb RD miss adr=%08h ack_seen=%0b", addr, seen);
        chk("miss_no_ack", {31'b0, seen}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("rst_status", 5'h10, 32'h0);
        rd_chk("rst_data", 5'h14, 32'h0);

        // Register map
        wr(5'h00, 32'h6745_2312);
        wr(5'h04, 32'hEFCD_AB89);
        wr(5'h08, 32'hFFFF_FFFF);
        rd_chk("frame_mask", 5'h08, 32'h003F_FFFF);
        wr(5'h08, 32'h0000_0134);
        rd_chk("frame_rb", 5'h08, 32'h0000_0134);
        rd_chk("key_lo_rb", 5'h00, 32'h6745_2312);
        rd_chk("key_hi_rb", 5'h04, 32'hEFCD_AB89);
        rd_chk("ctrl_rd0", 5'h0C, 32'h0);
        wr(5'h18, 32'hA5A5_A5A5);
        rd_chk("rsvd_rd0", 5'h18, 32'h0);

        // Reference vector, exact ready cycle, key write during run has no effect
        bus(1'b1, 5'h0C, 32'h1, q, a);
        wait_cycle(a + 5);
        wr(5'h00, 32'hDEAD_BEEF);
        wait_cycle(a + 60);
        rd_chk("v1_busy", 5'h10, 32'h1);
        wait_cycle(a + 218);
        rd_chk("v1_valid_218", 5'h10, 32'h2);
        bus(1'b0, 5'h14, 32'h0, q, r);
        chk("v1_word0", q, 32'h534E_AA58);
        rd_chk("v1_regen_busy", 5'h10, 32'h1);
        wait_cycle(r + 32);
        rd_chk("v1_word1", 5'h14, 32'h2FE8_151A);
        rd_chk("key_lo_new", 5'h00, 32'hDEAD_BEEF);

        // All-zero key and frame
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h08, 32'h0);
        bus(1'b1, 5'h0C, 32'h1, q, a);
        wait_cycle(a + 150);
        rd_chk("z_busy_mid", 5'h10, 32'h1);
        wait_cycle(a + 217);
        rd_chk("z_busy_217", 5'h10, 32'h1);
        rd_chk("z_valid", 5'h10, 32'h2);
        rd_chk("z_word", 5'h14, 32'h0);
        rd_chk("z_consumed", 5'h10, 32'h1);

        // DATA read while busy is inert
        wr(5'h00, 32'h6745_2312);
        wr(5'h04, 32'hEFCD_AB89);
        wr(5'h08, 32'h0000_0134);
        bus(1'b1, 5'h0C, 32'h1, q, a);
        wait_cycle(a + 40);
        rd_chk("busy_data0", 5'h14, 32'h0);
        rd_chk("busy_novalid", 5'h10, 32'h1);
        wait_cycle(a + 217);
        rd_chk("busy_217", 5'h10, 32'h1);
        rd_chk("busy_valid", 5'h10, 32'h2);
        rd_chk("busy_word", 5'h14, 32'h534E_AA58);

        // Restart 100 cycles into a run
        bus(1'b1, 5'h0C, 32'h1, q, a);
        wait_cycle(a + 100);
        bus(1'b1, 5'h0C, 32'h1, q, a2);
        wait_cycle(a2 + 217);
        rd_chk("rs_busy_217", 5'h10, 32'h1);
        rd_chk("rs_valid", 5'h10, 32'h2);
        rd_chk("rs_word", 5'h14, 32'h534E_AA58);

        // Reset pulse during MIX
        bus(1'b1, 5'h0C, 32'h1, q, a);
        wait_cycle(a + 120);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", {31'b0, ack}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("mr_status", 5'h10, 32'h0);
        rd_chk("mr_key_lo", 5'h00, 32'h0);
        rd_chk("mr_key_hi", 5'h04, 32'h0);
        rd_chk("mr_frame", 5'h08, 32'h0);
        rd_chk("mr_data", 5'h14, 32'h0);
        probe_miss(BASE + 32'h20);
        probe_miss(32'h2000_0014);
        wait_cycle(cyc_cnt + 250);
        rd_chk("mr_idle", 5'h10, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
